// File: rtl/exu_cal_pkg.sv
// Shared constants and types for the calculation centre: op-bundle layout,
// op flag positions and the shift FSM state encoding.
package exu_cal_pkg;

    // Op flag bit positions inside the one-hot flag field of the op bundle
    localparam int CAL_ADD = 0;
    localparam int CAL_SUB = 1;
    localparam int CAL_SLL = 2;
    localparam int CAL_SRL = 3;
    localparam int CAL_SRA = 4;
    localparam int CAL_XOR = 5;
    localparam int CAL_CMP = 6;

    // Operand field positions (33-bit operands, pre-extended by the ALU)
    localparam int CAL_OPN1_LSB = 7;
    localparam int CAL_OPN1_MSB = 39;
    localparam int CAL_OPN2_LSB = 40;
    localparam int CAL_OPN2_MSB = 72;

    localparam int CAL_OPB_SIZE = 73;

    // Shift sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } cal_state_e;

    // Shift distance is the low five bits of the second operand
    function automatic logic [4:0] getShamt(input logic [32:0] opn2);
        return opn2[4:0];
    endfunction

endpackage

// File: rtl/exu_cal_shstep.sv
// Combinational single-step shifter used by the iterative shift sequencer.
// dir_i = 1 shifts left; otherwise right, sign-filling when arith_i is set.
module exu_cal_shstep (
    input  logic [31:0] data_i,
    input  logic [5:0]  step_i,
    input  logic        dir_i,
    input  logic        arith_i,
    output logic [31:0] data_o
);

    // Apply one shift step of up to 32 positions in the selected direction
    always_comb begin
        if (dir_i) begin
            data_o = data_i << step_i;
        end else if (arith_i) begin
            data_o = 32'($signed(data_i) >>> step_i);
        end else begin
            data_o = data_i >> step_i;
        end
    end

endmodule

// File: rtl/exu_cal.sv
// Calculation centre behind the ALU stage. ADD/SUB/XOR/CMP and zero-distance
// shifts answer combinationally in IDLE; other shifts iterate SHIFT_STEP
// positions per cycle and present the result in DONE until accepted.
module exu_cal
    import exu_cal_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hs_al4cal_val,
    output logic                    hs_cal4al_rdy,
    input  logic [CAL_OPB_SIZE-1:0] i_cal_opb,
    output logic [31:0]             o_cal_res,
    output logic                    o_cal_busy
);

    cal_state_e  state_q, state_d;
    logic [31:0] shReg_q, shReg_d;
    logic [4:0]  rem_q, rem_d;
    logic        left_q, left_d;
    logic        arith_q, arith_d;

    logic [32:0] opn1;
    logic [32:0] opn2;
    logic [4:0]  shamt;
    logic        isShift;
    logic [31:0] singleRes;
    logic [5:0]  stepAmt;
    logic [31:0] stepped;

    assign opn1    = i_cal_opb[CAL_OPN1_MSB:CAL_OPN1_LSB];
    assign opn2    = i_cal_opb[CAL_OPN2_MSB:CAL_OPN2_LSB];
    assign shamt   = getShamt(opn2);
    assign isShift = i_cal_opb[CAL_SLL] | i_cal_opb[CAL_SRL] | i_cal_opb[CAL_SRA];

    // Result of the ops that finish in the request cycle; no flag gives zero
    always_comb begin
        singleRes = '0;
        if (i_cal_opb[CAL_ADD]) begin
            singleRes = opn1[31:0] + opn2[31:0];
        end else if (i_cal_opb[CAL_SUB]) begin
            singleRes = opn1[31:0] - opn2[31:0];
        end else if (i_cal_opb[CAL_XOR]) begin
            singleRes = opn1[31:0] ^ opn2[31:0];
        end else if (i_cal_opb[CAL_CMP]) begin
            singleRes = {31'b0, ($signed(opn1) < $signed(opn2))};
        end else if (isShift) begin
            singleRes = opn1[31:0];
        end
    end

    // Step size this cycle is the smaller of the remaining distance and SHIFT_STEP
    always_comb begin
        if ({1'b0, rem_q} < 6'(SHIFT_STEP)) begin
            stepAmt = {1'b0, rem_q};
        end else begin
            stepAmt = 6'(SHIFT_STEP);
        end
    end

    exu_cal_shstep u_shstep (
        .data_i  (shReg_q),
        .step_i  (stepAmt),
        .dir_i   (left_q),
        .arith_i (arith_q),
        .data_o  (stepped)
    );

    // Shift sequencer next-state and handshake outputs
    always_comb begin
        state_d       = state_q;
        shReg_d       = shReg_q;
        rem_d         = rem_q;
        left_d        = left_q;
        arith_d       = arith_q;
        hs_cal4al_rdy = 1'b0;
        o_cal_res     = '0;
        case (state_q)
            ST_IDLE: begin
                if (hs_al4cal_val) begin
                    if (isShift && (shamt != 5'd0)) begin
                        shReg_d = opn1[31:0];
                        rem_d   = shamt;
                        left_d  = i_cal_opb[CAL_SLL];
                        arith_d = i_cal_opb[CAL_SRA];
                        state_d = ST_SHIFT;
                    end else begin
                        hs_cal4al_rdy = 1'b1;
                        o_cal_res     = singleRes;
                    end
                end
            end
            ST_SHIFT: begin
                if (!hs_al4cal_val) begin
                    state_d = ST_IDLE;
                end else begin
                    shReg_d = stepped;
                    rem_d   = rem_q - stepAmt[4:0];
                    if (rem_d == 5'd0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!hs_al4cal_val) begin
                    state_d = ST_IDLE;
                end else begin
                    hs_cal4al_rdy = 1'b1;
                    o_cal_res     = shReg_q;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any shift in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shReg_q <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shReg_q <= shReg_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign o_cal_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exu_cal.sv
// Directed self-checking bench for exu_cal with SHIFT_STEP = 4.
module tb_exu_cal;
    import exu_cal_pkg::*;

    logic                    clk;
    logic                    rst;
    logic                    val;
    logic                    rdy;
    logic [CAL_OPB_SIZE-1:0] opb;
    logic [31:0]             res;
    logic                    busy;

    int testCount;
    int failCount;

    exu_cal #(.SHIFT_STEP(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_al4cal_val (val),
        .hs_cal4al_rdy (rdy),
        .i_cal_opb     (opb),
        .o_cal_res     (res),
        .o_cal_busy    (busy)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; op < 0 means no flag set
    task automatic applyStimulus(input logic v, input int op,
                                 input logic [32:0] a, input logic [32:0] b);
        logic [CAL_OPB_SIZE-1:0] bundle;
        bundle = '0;
        if (op >= 0) bundle[op] = 1'b1;
        bundle[CAL_OPN1_MSB:CAL_OPN1_LSB] = a;
        bundle[CAL_OPN2_MSB:CAL_OPN2_LSB] = b;
        opb = bundle;
        val = v;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue a multi-cycle shift, count clock edges until rdy, check result and accept
    task automatic runShift(input string tag, input int op, input logic [32:0] a,
                            input logic [32:0] b, input int expEdges,
                            input logic [31:0] expRes);
        int edges;
        @(negedge clk);
        applyStimulus(1'b1, op, a, b);
        #1;
        checkOutput({tag, " rdy in request cycle"}, {31'b0, rdy}, 32'd0);
        edges = 0;
        while (rdy !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, " edges to rdy"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, " result"}, res, expRes);
        checkOutput({tag, " busy in done"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, -1, 33'd0, 33'd0);
        #1;
        checkOutput({tag, " busy after accept"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, -1, 33'd0, 33'd0);

        #2;
        checkOutput("reset rdy", {31'b0, rdy}, 32'd0);
        checkOutput("reset res", res, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD wraps modulo 2^32, answered in the same cycle
        @(negedge clk);
        applyStimulus(1'b1, CAL_ADD, 33'h0FFFFFFFF, 33'h000000001);
        #1;
        checkOutput("add rdy", {31'b0, rdy}, 32'd1);
        checkOutput("add wrap res", res, 32'h00000000);

        // SUB borrows through zero
        @(negedge clk);
        applyStimulus(1'b1, CAL_SUB, 33'd5, 33'd7);
        #1;
        checkOutput("sub res", res, 32'hFFFFFFFE);

        // CMP signed: -1 < 1
        @(negedge clk);
        applyStimulus(1'b1, CAL_CMP, 33'h1FFFFFFFF, 33'h000000001);
        #1;
        checkOutput("cmp signed res", res, 32'd1);

        // CMP unsigned-extended: 0xFFFFFFFF < 1 is false
        @(negedge clk);
        applyStimulus(1'b1, CAL_CMP, 33'h0FFFFFFFF, 33'h000000001);
        #1;
        checkOutput("cmp unsigned res", res, 32'd0);

        // No flag set: accepted with zero result
        @(negedge clk);
        applyStimulus(1'b1, -1, 33'h012345678, 33'h000000001);
        #1;
        checkOutput("noop rdy", {31'b0, rdy}, 32'd1);
        checkOutput("noop res", res, 32'd0);

        // Zero-distance shift passes opn1 through in the same cycle
        @(negedge clk);
        applyStimulus(1'b1, CAL_SLL, 33'h012345678, 33'd0);
        #1;
        checkOutput("sll0 rdy", {31'b0, rdy}, 32'd1);
        checkOutput("sll0 res", res, 32'h12345678);
        checkOutput("sll0 busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, -1, 33'd0, 33'd0);

        // SRA by 31 of 0x80000000: load edge plus 8 step edges
        runShift("sra31", CAL_SRA, 33'h080000000, 33'd31, 9, 32'hFFFFFFFF);

        // SLL by 5: load edge plus 2 step edges
        runShift("sll5", CAL_SLL, 33'h012345678, 33'd5, 3, 32'h468ACF00);

        // SRL by 4 is a single step
        runShift("srl4", CAL_SRL, 33'h080000000, 33'd4, 2, 32'h08000000);

        // Upper shift-amount bits ignored: 36 acts as 4
        runShift("sll36", CAL_SLL, 33'h000000001, 33'h000000024, 2, 32'h00000010);

        // Abort: drop val mid-shift, sequencer returns to IDLE one edge later
        @(negedge clk);
        applyStimulus(1'b1, CAL_SRL, 33'h0DEADBEEF, 33'd20);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, -1, 33'd0, 33'd0);
        #1;
        checkOutput("abort busy before", {31'b0, busy}, 32'd1);
        checkOutput("abort rdy", {31'b0, rdy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort busy after", {31'b0, busy}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, CAL_XOR, 33'h0F0F0F0F0, 33'h00F0F0F0F);
        #1;
        checkOutput("xor rdy", {31'b0, rdy}, 32'd1);
        checkOutput("xor res", res, 32'hFFFFFFFF);

        // Reset mid-shift clears busy without waiting for a clock edge
        @(negedge clk);
        applyStimulus(1'b1, CAL_SRL, 33'h0FFFF0000, 33'd31);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("midreset busy before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midreset busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset rdy", {31'b0, rdy}, 32'd0);
        applyStimulus(1'b0, -1, 33'd0, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, CAL_ADD, 33'd2, 33'd3);
        #1;
        checkOutput("post reset add rdy", {31'b0, rdy}, 32'd1);
        checkOutput("post reset add res", res, 32'd5);
        @(negedge clk);
        applyStimulus(1'b0, -1, 33'd0, 33'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
